mask_sched: RTL

- Sequencer for the activation mask stage.
- Per pass, it walks the activation line buffer depth (channel words) and the kernel column taps. It issues RAM read addresses and a column-offset sideband time-aligned with the RAM read data, so the mask can form each PE's window row (p*stride + col_off).
- Handles config validation, downstream backpressure and the pass-complete indication.

---
 rtl/mask_sched.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mask_sched.sv
// rtl/mask_sched.sv - activation mask read sequencer: line-buffer address/tap walk with 1-cycle aligned sideband
module mask_sched #(
    parameter int Ram_Row    = 33,
    parameter int Data_Width = 64,
    parameter int Pe_Mac     = 14,
    parameter int deep       = 512
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [2:0]               kernel_size,
    input  logic [1:0]               stride,
    input  logic [$clog2(deep):0]    ram_deep,
    input  logic                     tready,
    output logic                     rd_en,
    output logic [$clog2(deep)-1:0]  rd_addr,
    output logic                     out_valid,
    output logic [2:0]               col_off,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done,
    output logic                     cfg_err
);

    localparam int AW = $clog2(deep);

    // Row words carry no data through this block; a degenerate geometry simply rejects every pass.
    localparam bit GEOM_OK = (Data_Width > 0) && (Pe_Mac > 0) && (Ram_Row > 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    logic [2:0]    k_q;
    logic [AW:0]   depth_q;
    logic [AW-1:0] d;
    logic [2:0]    kx;

    logic          issue;
    logic          tap_wrap;
    logic          last_beat;
    logic          cfg_legal;
    int            span;

    // Issue gate and end-of-word / end-of-pass detection from the current counters.
    always_comb begin
        issue     = (state == RUN) && tready && !abort;
        tap_wrap  = (kx == (k_q - 3'd1));
        last_beat = tap_wrap && ({1'b0, d} == (depth_q - (AW+1)'(1)));
    end

    // Window span across all PE lanes must fit inside the rows presented per read.
    always_comb begin
        span      = (Pe_Mac - 1) * int'(stride) + int'(kernel_size);
        cfg_legal = GEOM_OK
                    && kernel_size[0]
                    && ((stride == 2'd1) || (stride == 2'd2))
                    && (ram_deep != '0)
                    && (32'(ram_deep) <= 32'(deep))
                    && (span <= Ram_Row);
    end

    assign rd_en   = issue;
    assign rd_addr = d;

    // Pass FSM, tap/word counters and the read-latency-aligned sideband.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            k_q       <= '0;
            depth_q   <= '0;
            d         <= '0;
            kx        <= '0;
            out_valid <= 1'b0;
            col_off   <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            out_valid <= issue;
            col_off   <= issue ? kx : 3'd0;
            out_last  <= issue && last_beat;

            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        k_q     <= kernel_size;
                        depth_q <= ram_deep;
                        d       <= '0;
                        kx      <= '0;
                        if (cfg_legal) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        d     <= '0;
                        kx    <= '0;
                    end else if (issue) begin
                        if (last_beat) begin
                            state <= DRAIN;
                            d     <= '0;
                            kx    <= '0;
                        end else if (tap_wrap) begin
                            kx <= '0;
                            d  <= d + AW'(1);
                        end else begin
                            kx <= kx + 3'd1;
                        end
                    end
                end
                DRAIN: begin
                    // The last beat's out_valid/out_last is on the bus this cycle.
                    busy <= 1'b0;
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
